// File: rtl/sdram_read.sv
// Single-word SDRAM read engine (CL=2/3, BL=1): ACTIVE, READ with auto-precharge,
// one 16-bit capture, precharge recovery. Pins go high-Z when the bus is not owned.
module sdram_read #(
  parameter int T_RCD       = 2,
  parameter int CAS_LATENCY = 2,
  parameter int T_RP        = 2
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq,
  input  logic        ienb,
  input  logic [24:0] iaddr,
  output logic [15:0] odata,
  output logic        ofin,
  output logic        obusy,
  output logic        DRAM_CLK,
  output logic        DRAM_CKE,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_LDQM,
  output logic        DRAM_UDQM,
  input  logic [15:0] DRAM_DQ
);

  localparam int CMAX_A = (T_RCD > CAS_LATENCY) ? T_RCD : CAS_LATENCY;
  localparam int CMAX   = (CMAX_A > T_RP) ? CMAX_A : T_RP;
  localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] RCD_LAST = CW'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [CW-1:0] CL_LAST  = CW'(CAS_LATENCY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'((T_RP > 1) ? T_RP - 2 : 0);

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD, S_RD, S_CL, S_CAP, S_RP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [24:0]   lat_q, lat_n;
  logic [3:0]    cmd_q, cmd_n;
  logic [1:0]    ba_q, ba_n;
  logic [12:0]   addr_q, addr_n;
  logic [1:0]    dqm_q, dqm_n;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      lat_q  <= '0;
      cmd_q  <= CMD_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      dqm_q  <= 2'b11;
      odata  <= '0;
      ofin   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= (state_n != state) ? '0 : cnt + CW'(1);
      lat_q  <= lat_n;
      cmd_q  <= cmd_n;
      ba_q   <= ba_n;
      addr_q <= addr_n;
      dqm_q  <= dqm_n;
      ofin   <= (state_n == S_CAP);
      if (state == S_CL && state_n == S_CAP)
        odata <= DRAM_DQ;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (ireq) state_n = S_ACT;
      S_ACT:  state_n = (T_RCD == 1) ? S_RD : S_RCD;
      S_RCD:  if (cnt == RCD_LAST) state_n = S_RD;
      S_RD:   state_n = S_CL;
      S_CL:   if (cnt == CL_LAST) state_n = S_CAP;
      S_CAP:  state_n = (T_RP == 1) ? S_IDLE : S_RP;
      S_RP:   if (cnt == RP_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so each command appears in its own state's cycle.
  always_comb begin
    lat_n  = (state == S_IDLE && ireq) ? iaddr : lat_q;
    cmd_n  = CMD_NOP;
    ba_n   = ba_q;
    addr_n = addr_q;
    dqm_n  = 2'b11;
    case (state_n)
      S_ACT: begin
        cmd_n  = CMD_ACTIVE;
        ba_n   = lat_n[24:23];
        addr_n = lat_n[22:10];
      end
      S_RD: begin
        cmd_n  = CMD_READ;
        ba_n   = lat_n[24:23];
        addr_n = {2'b00, 1'b1, lat_n[9:0]};
        dqm_n  = 2'b00;
      end
      S_CL:    dqm_n = 2'b00;
      default: ;
    endcase
  end

  assign obusy = (state != S_IDLE);

  assign DRAM_CLK   = ienb ? ~iclk    : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q   : {13{1'bz}};
  assign DRAM_BA    = ienb ? ba_q     : 2'bzz;
  assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: directed table, hand sequences and randomized traffic
// checked against a relative-cycle timeline model of a single read access.
module tb_sdram_read;
  localparam int RCD = 2, CL = 2, RP = 2;
  localparam int LAT = 2 + RCD + CL + RP;

  logic        clk = 1'b0;
  logic        rst, req, enb;
  logic [24:0] addr;
  logic [15:0] dq;
  wire  [15:0] odata;
  wire         ofin, obusy, dclk, dcke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
  wire  [12:0] daddr;
  wire  [1:0]  dba;
  wire  [3:0]  cmd = {cs_n, ras_n, cas_n, we_n};
  wire  [1:0]  dqm = {udqm, ldqm};

  logic        req2, enb2;
  logic [24:0] addr2;
  logic [15:0] dq2;
  wire  [15:0] odata2;
  wire         ofin2, obusy2, dclk2, dcke2, cs2, ras2, cas2, we2, ldqm2, udqm2;
  wire  [12:0] daddr2;
  wire  [1:0]  dba2;
  wire  [3:0]  cmd2 = {cs2, ras2, cas2, we2};

  always #5 clk = ~clk;

  sdram_read u_dut (
    .iclk(clk), .ireset(rst), .ireq(req), .ienb(enb), .iaddr(addr),
    .odata(odata), .ofin(ofin), .obusy(obusy),
    .DRAM_CLK(dclk), .DRAM_CKE(dcke), .DRAM_ADDR(daddr), .DRAM_BA(dba),
    .DRAM_CS_N(cs_n), .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
    .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm), .DRAM_DQ(dq));

  sdram_read #(.T_RCD(3), .CAS_LATENCY(3), .T_RP(3)) u_dut3 (
    .iclk(clk), .ireset(rst), .ireq(req2), .ienb(enb2), .iaddr(addr2),
    .odata(odata2), .ofin(ofin2), .obusy(obusy2),
    .DRAM_CLK(dclk2), .DRAM_CKE(dcke2), .DRAM_ADDR(daddr2), .DRAM_BA(dba2),
    .DRAM_CS_N(cs2), .DRAM_RAS_N(ras2), .DRAM_CAS_N(cas2), .DRAM_WE_N(we2),
    .DRAM_LDQM(ldqm2), .DRAM_UDQM(udqm2), .DRAM_DQ(dq2));

  int tests = 0, fails = 0;
  int cyc = 0;

  // Model: a single access timeline anchored at the cycle whose edge accepted it.
  int          acc = -1000;
  logic [24:0] addr_m = '0;
  logic [15:0] odata_m = '0;
  logic [15:0] dq_hist [4096];
  logic        fin_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic q, input logic [24:0] a,
                       input logic e, input logic [15:0] d);
    int  rel;
    logic busy_e, fin_e;
    logic [3:0] cmd_e;
    logic [1:0] dqm_e;
    rst = r; req = q; addr = a; enb = e; dq = d;
    dq_hist[cyc % 4096] = d;
    @(negedge clk);
    rel    = cyc - acc;
    busy_e = (rel >= 1) && (rel < LAT);
    fin_e  = (rel == 2 + RCD + CL);
    cmd_e  = (rel == 1) ? 4'b0011 : (rel == 1 + RCD) ? 4'b0101 : 4'b0111;
    dqm_e  = (rel >= 1 + RCD && rel <= 1 + RCD + CL) ? 2'b00 : 2'b11;
    if (fin_e) odata_m = dq_hist[(cyc - 1) % 4096];
    fin_seen = ofin;
    if (e) begin
      chk("cmd", {28'd0, cmd}, {28'd0, cmd_e});
      chk("dqm", {30'd0, dqm}, {30'd0, dqm_e});
      chk("cke", {31'd0, dcke}, 32'd1);
      chk("dram_clk", {31'd0, dclk}, 32'd1);
      if (rel == 1) begin
        chk("act_ba", {30'd0, dba}, {30'd0, addr_m[24:23]});
        chk("act_row", {19'd0, daddr}, {19'd0, addr_m[22:10]});
      end
      if (rel == 1 + RCD) begin
        chk("rd_ba", {30'd0, dba}, {30'd0, addr_m[24:23]});
        chk("rd_col", {19'd0, daddr}, {19'd0, 3'b001, addr_m[9:0]});
      end
    end else begin
      chk("z_cmd", {28'd0, cmd}, {28'd0, 4'bzzzz});
      chk("z_dqm", {30'd0, dqm}, {30'd0, 2'bzz});
      chk("z_ba", {30'd0, dba}, {30'd0, 2'bzz});
      chk("z_addr", {19'd0, daddr}, {19'd0, {13{1'bz}}});
      chk("z_cke", {31'd0, dcke}, {31'd0, 1'bz});
      chk("z_clk", {31'd0, dclk}, {31'd0, 1'bz});
    end
    chk("ofin", {31'd0, ofin}, {31'd0, fin_e});
    chk("obusy", {31'd0, obusy}, {31'd0, busy_e});
    chk("odata", {16'd0, odata}, {16'd0, odata_m});
    if (r) begin
      acc = -1000;
      odata_m = '0;
    end else if (!busy_e && q) begin
      acc = cyc;
      addr_m = a;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step(input logic r, input logic q, input logic [24:0] a,
                      input logic e, input logic [15:0] d);
    apply(r, q, a, e, d);
    tick();
  endtask

  typedef struct {
    logic        req;
    logic [15:0] dq;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        chk_a;
    logic [1:0]  dqm;
    logic        fin;
    logic        busy;
    logic [15:0] od;
  } vec_t;

  vec_t tbl [10];
  localparam logic [24:0] A0 = {2'b10, 13'h0ABC, 10'h155};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fins [$];
    int s, read_at, fin_at, idle_at;
    logic [15:0] od3;

    tbl[0] = '{1'b1, 16'h0000, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 16'h0000, 4'h3, 2'b10, 13'h0ABC, 1'b1, 2'b11, 1'b0, 1'b1, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b0, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 4'h5, 2'b10, 13'h0555, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 16'h1111, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0000};
    tbl[5] = '{1'b0, 16'hBEEF, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 16'h2222, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b1, 1'b1, 16'hBEEF};
    tbl[7] = '{1'b0, 16'h0000, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b0, 1'b1, 16'hBEEF};
    tbl[8] = '{1'b0, 16'h0000, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 16'hBEEF};
    tbl[9] = '{1'b0, 16'h0000, 4'h7, 2'b00, 13'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 16'hBEEF};

    rst = 1'b1; req = 1'b0; enb = 1'b1; addr = '0; dq = '0;
    req2 = 1'b0; enb2 = 1'b1; addr2 = '0; dq2 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", {19'd0, daddr}, 32'd0);
    chk("rst_ba", {30'd0, dba}, 32'd0);
    chk("rst_cmd", {28'd0, cmd}, 32'h7);
    chk("rst_dqm", {30'd0, dqm}, 32'h3);
    chk("rst_odata", {16'd0, odata}, 32'd0);
    chk("rst_ofin", {31'd0, ofin}, 32'd0);
    chk("rst_obusy", {31'd0, obusy}, 32'd0);
    tick();
    step(0, 0, '0, 1, 16'h0);

    // Directed single access against constant per-cycle expectations
    for (int i = 0; i < 10; i++) begin
      apply(0, tbl[i].req, A0, 1, tbl[i].dq);
      chk($sformatf("tbl%0d_cmd", i), {28'd0, cmd}, {28'd0, tbl[i].cmd});
      chk($sformatf("tbl%0d_dqm", i), {30'd0, dqm}, {30'd0, tbl[i].dqm});
      chk($sformatf("tbl%0d_ofin", i), {31'd0, ofin}, {31'd0, tbl[i].fin});
      chk($sformatf("tbl%0d_obusy", i), {31'd0, obusy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_odata", i), {16'd0, odata}, {16'd0, tbl[i].od});
      if (tbl[i].chk_a) begin
        chk($sformatf("tbl%0d_ba", i), {30'd0, dba}, {30'd0, tbl[i].ba});
        chk($sformatf("tbl%0d_addr", i), {19'd0, daddr}, {19'd0, tbl[i].a});
      end
      tick();
    end
    for (int i = 10; i <= 20; i++) step(0, 0, $urandom, 1, 16'(($urandom)));
    chk("odata_hold", {16'd0, odata}, 32'h0000BEEF);

    // ireq held high: accesses every LAT cycles with the address of each accept edge
    s = cyc;
    fins.delete();
    for (int i = 0; i < 40; i++) begin
      apply(0, (i < 30), 25'($urandom), 1, 16'($urandom));
      if (fin_seen) fins.push_back(cyc - s);
      tick();
    end
    chk("b2b_count", fins.size(), 32'd4);
    for (int i = 0; i < fins.size(); i++)
      chk($sformatf("b2b_fin%0d", i), fins[i], 32'(2 + RCD + CL + i * LAT));

    // Reset during CAS latency abandons the access
    step(0, 1, 25'h1234567, 1, 16'h0);
    for (int i = 1; i < 4; i++) step(0, 0, '0, 1, 16'h5A5A);
    step(1, 0, '0, 1, 16'h5A5A);
    apply(0, 0, '0, 1, 16'h0);
    chk("midrst_cmd", {28'd0, cmd}, 32'h7);
    chk("midrst_dqm", {30'd0, dqm}, 32'h3);
    chk("midrst_odata", {16'd0, odata}, 32'd0);
    chk("midrst_obusy", {31'd0, obusy}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 16'h0);
    for (int i = 0; i < 10; i++) step(0, (i == 0), 25'h0AAAAAA, 1, 16'hC0DE + 16'(i));
    chk("post_rst_odata", {16'd0, odata}, 32'h0000C0E3);

    // Bus not owned: pins float, access still completes
    fin_at = -1;
    for (int i = 0; i < 10; i++) begin
      apply(0, (i == 0), 25'h1555555, 0, 16'h7000 + 16'(i));
      if (fin_seen && fin_at < 0) fin_at = i;
      tick();
    end
    chk("noown_fin_at", fin_at, 32'd6);
    step(0, 0, '0, 1, 16'h0);
    step(0, 0, '0, 1, 16'h0);

    // Randomized traffic with occasional reset and bus release
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), 25'($urandom),
           ($urandom_range(0, 3) != 0), 16'($urandom));

    // Parameterised instance: T_RCD=3, CAS_LATENCY=3, T_RP=3
    read_at = -1; fin_at = -1; idle_at = -1; od3 = '0;
    for (int r = 0; r < 15; r++) begin
      req2 = (r == 0);
      addr2 = 25'h0F0F0F0;
      dq2 = (r == 7) ? 16'h1234 : 16'hEEEE;
      @(negedge clk);
      if (r == 1) chk("p3_act", {28'd0, cmd2}, 32'h3);
      if (cmd2 == 4'b0101 && read_at < 0) read_at = r;
      if (ofin2 && fin_at < 0) begin fin_at = r; od3 = odata2; end
      if (r > 0 && !obusy2 && idle_at < 0) idle_at = r;
      @(posedge clk); #1;
    end
    chk("p3_read_at", read_at, 32'd4);
    chk("p3_fin_at", fin_at, 32'd8);
    chk("p3_idle_at", idle_at, 32'd11);
    chk("p3_odata", {16'd0, od3}, 32'h00001234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
